// File: rtl/mux_n_scan_pkg.sv
// Shared definitions for the scanning multiplexer and related display drivers.
package mux_n_scan_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Ceiling log2 that never returns less than 1, so a one-value range still gets a bit.
   function automatic int clog2_min1(input int value);
      int r;
      r = $clog2(value);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Combinational round-robin search: the next index above i_ch (wrapping) whose mask bit is set.
module mux_next_ch
   import mux_n_scan_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int SEL_W = clog2_min1(N_CH)
) (
   input  logic [SEL_W-1:0] i_ch,
   input  logic [N_CH-1:0]  i_mask,
   output logic [SEL_W-1:0] o_next_ch,
   output logic             o_none
);

   assign o_none = (i_mask == '0);

   // Walk offsets 1..N_CH; offset N_CH lands on i_ch itself, so a lone set bit on i_ch holds.
   always_comb begin
      logic found;
      int   idx;
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      o_next_ch = i_ch;
      found     = 1'b0;
      idx       = 0;
      for (int i = 1; i <= N_CH; i++) begin
         idx = (int'(i_ch) + i) % N_CH;
         if (!found && i_mask[idx]) begin
            o_next_ch = SEL_W'(idx);
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_n_scan.sv
// N-channel registered multiplexer with manual select and prescaled round-robin auto-scan.
module mux_n_scan
   import mux_n_scan_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int N_CH  = 4,
   parameter int SEL_W = clog2_min1(N_CH),
   parameter int DIV   = 50000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_mode,
   input  logic [SEL_W-1:0]      i_sel,
   input  logic [N_CH*WIDTH-1:0] i_w,
   input  logic [N_CH-1:0]       i_mask,
   output logic [WIDTH-1:0]      o_f,
   output logic [SEL_W-1:0]      o_ch,
   output logic [N_CH-1:0]       o_onehot,
   output logic                  o_tick
);

   localparam int            PW         = clog2_min1(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   logic [SEL_W-1:0] ch_q, ch_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] f_q, f_d;
   logic [N_CH-1:0]  onehot_q, onehot_d;
   logic             tick_q, tick_d;

   logic [SEL_W-1:0] scan_next_ch;
   logic             mask_none;
   logic             sel_valid;
   logic             blank;

   mux_next_ch #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_next_ch (
      .i_ch      (ch_q),
      .i_mask    (i_mask),
      .o_next_ch (scan_next_ch),
      .o_none    (mask_none)
   );

   // Selects wider than the channel count can name channels that do not exist.
   assign sel_valid = (32'(i_sel) < N_CH);

   // Channel and prescaler update: disabled holds, manual follows i_sel, scan advances on wrap.
   always_comb begin
      ch_d    = ch_q;
      presc_d = presc_q;
      blank   = 1'b1;
      if (i_en) begin
         if (i_mode == MODE_MANUAL) begin
            presc_d = '0;
            blank   = 1'b0;
            if (sel_valid) begin
               ch_d = i_sel;
            end
         end else begin
            // With nothing to visit the display goes dark but the dwell timer keeps running.
            blank = mask_none;
            if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               ch_d    = scan_next_ch;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
      end
   end

   // Output data, digit enable and change pulse, all computed from the channel about to be registered.
   always_comb begin
      f_d      = '0;
      onehot_d = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (!blank && ch_d == SEL_W'(k)) begin
            f_d         = i_w[k*WIDTH +: WIDTH];
            onehot_d[k] = 1'b1;
         end
      end
      tick_d = (ch_d != ch_q);
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ch_q     <= '0;
         presc_q  <= '0;
         f_q      <= '0;
         onehot_q <= '0;
         tick_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         ch_q     <= ch_d;
         presc_q  <= presc_d;
         f_q      <= f_d;
         onehot_q <= onehot_d;
         tick_q   <= tick_d;
      end
   end

   assign o_f      = f_q;
   assign o_ch     = ch_q;
   assign o_onehot = onehot_q;
   assign o_tick   = tick_q;

endmodule

// File: tb/tb_mux_n_scan.sv
// Directed-vector bench for mux_n_scan: a 4-channel instance and a 3-channel instance, both DIV=3.
module tb_mux_n_scan;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        mode;

   logic [1:0]  sel;
   logic [15:0] w;
   logic [3:0]  mask;
   logic [3:0]  f;
   logic [1:0]  ch;
   logic [3:0]  onehot;
   logic        tick;

   logic [1:0]  sel3;
   logic [11:0] w3;
   logic [2:0]  mask3;
   logic [3:0]  f3;
   logic [1:0]  ch3;
   logic [2:0]  onehot3;
   logic        tick3;

   int n_cmp = 0;
   int n_bad = 0;

   // Channel k data for w = 16'hDCBA: channel k sits in bits [4k+3:4k].
   logic [3:0] dat [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

   mux_n_scan #(.WIDTH(4), .N_CH(4), .DIV(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sel(sel),
      .i_w(w), .i_mask(mask), .o_f(f), .o_ch(ch), .o_onehot(onehot), .o_tick(tick)
   );

   mux_n_scan #(.WIDTH(4), .N_CH(3), .DIV(3)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sel(sel3),
      .i_w(w3), .i_mask(mask3), .o_f(f3), .o_ch(ch3), .o_onehot(onehot3), .o_tick(tick3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for two edges, release 1 ns after an edge; the next edge is "edge 1".
   task automatic do_reset(input logic m);
      rst_n = 1'b0;
      en    = 1'b1;
      mode  = m;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; mode = 1'b1; mask = 4'hF; sel = 2'd0; w = 16'hDCBA;
      step();
      n_cmp++; if ({f, ch, onehot, tick} !== 11'd0) begin n_bad++; $display("FAIL reset_state got %h want 000", {f, ch, onehot, tick}); end
      rst_n = 1'b1;
      repeat (10) step();
      // After 10 scan edges ch=3 and f=D, so a clear is observable.
      #2; rst_n = 1'b0; #1;
      n_cmp++; if ({f, ch, onehot, tick} !== 11'd0) begin n_bad++; $display("FAIL async_reset got %h want 000", {f, ch, onehot, tick}); end
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         n_cmp++; if (tick !== (k == 3)) begin n_bad++; $display("FAIL reset_first_tick edge %0d got %b want %b", k, tick, (k == 3)); end
         n_cmp++; if (ch !== ((k == 3) ? 2'd1 : 2'd0)) begin n_bad++; $display("FAIL reset_first_ch edge %0d got %0d", k, ch); end
      end
   endtask

   task automatic test_manual();
      w = 16'hDCBA; sel = 2'd0;
      do_reset(1'b0);
      step();
      n_cmp++; if ({f, ch, onehot, tick} !== {4'hA, 2'd0, 4'b0001, 1'b0}) begin n_bad++; $display("FAIL manual_sel0 got %h want %h", {f, ch, onehot, tick}, {4'hA, 2'd0, 4'b0001, 1'b0}); end
      sel = 2'd2;
      step();
      n_cmp++; if ({f, ch, onehot, tick} !== {4'hC, 2'd2, 4'b0100, 1'b1}) begin n_bad++; $display("FAIL manual_sel2 got %h want %h", {f, ch, onehot, tick}, {4'hC, 2'd2, 4'b0100, 1'b1}); end
      step();
      n_cmp++; if ({ch, tick} !== {2'd2, 1'b0}) begin n_bad++; $display("FAIL manual_hold got %h want %h", {ch, tick}, {2'd2, 1'b0}); end
      w = 16'hD5BA;
      step();
      n_cmp++; if (f !== 4'h5) begin n_bad++; $display("FAIL manual_data_change got %h want 5", f); end
      sel = 2'd3; w = 16'hDCBA;
      step();
      n_cmp++; if ({f, ch, onehot, tick} !== {4'hD, 2'd3, 4'b1000, 1'b1}) begin n_bad++; $display("FAIL manual_sel3 got %h want %h", {f, ch, onehot, tick}, {4'hD, 2'd3, 4'b1000, 1'b1}); end
   endtask

   task automatic test_full_scan();
      logic [1:0] e_ch;
      w = 16'hDCBA; mask = 4'hF;
      do_reset(1'b1);
      for (int k = 1; k <= 13; k++) begin
         step();
         e_ch = 2'((k / 3) % 4);
         n_cmp++; if (ch !== e_ch) begin n_bad++; $display("FAIL scan_ch edge %0d got %0d want %0d", k, ch, e_ch); end
         n_cmp++; if (f !== dat[e_ch]) begin n_bad++; $display("FAIL scan_f edge %0d got %h want %h", k, f, dat[e_ch]); end
         n_cmp++; if (tick !== (k % 3 == 0)) begin n_bad++; $display("FAIL scan_tick edge %0d got %b want %b", k, tick, (k % 3 == 0)); end
         n_cmp++; if (onehot !== (4'b0001 << e_ch)) begin n_bad++; $display("FAIL scan_onehot edge %0d got %b want %b", k, onehot, (4'b0001 << e_ch)); end
      end
   endtask

   task automatic test_masked_scan();
      logic [1:0] e_ch;
      w = 16'hDCBA; mask = 4'b1010;
      do_reset(1'b1);
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k < 3) e_ch = 2'd0;
         else       e_ch = ((k / 3) % 2 == 1) ? 2'd1 : 2'd3;
         n_cmp++; if (ch !== e_ch) begin n_bad++; $display("FAIL masked_ch edge %0d got %0d want %0d", k, ch, e_ch); end
         n_cmp++; if (tick !== (k % 3 == 0)) begin n_bad++; $display("FAIL masked_tick edge %0d got %b want %b", k, tick, (k % 3 == 0)); end
      end
      mask = 4'b0000;
      step();
      n_cmp++; if ({f, ch, onehot, tick} !== {4'h0, 2'd3, 4'b0000, 1'b0}) begin n_bad++; $display("FAIL mask_none_blank got %h want %h", {f, ch, onehot, tick}, {4'h0, 2'd3, 4'b0000, 1'b0}); end
      step(); step();
      n_cmp++; if ({ch, tick} !== {2'd3, 1'b0}) begin n_bad++; $display("FAIL mask_none_frozen got %h want %h", {ch, tick}, {2'd3, 1'b0}); end
      mask = 4'b0100;
      step();
      n_cmp++; if ({f, ch, onehot} !== {4'hD, 2'd3, 4'b1000}) begin n_bad++; $display("FAIL mask_restore_show got %h want %h", {f, ch, onehot}, {4'hD, 2'd3, 4'b1000}); end
      step(); step();
      n_cmp++; if ({f, ch, onehot, tick} !== {4'hC, 2'd2, 4'b0100, 1'b1}) begin n_bad++; $display("FAIL mask_restore_advance got %h want %h", {f, ch, onehot, tick}, {4'hC, 2'd2, 4'b0100, 1'b1}); end
   endtask

   task automatic test_out_of_range();
      w3 = 12'h765; mask3 = 3'b111; sel3 = 2'd1;
      do_reset(1'b0);
      step();
      n_cmp++; if ({f3, ch3, onehot3, tick3} !== {4'h6, 2'd1, 3'b010, 1'b1}) begin n_bad++; $display("FAIL oor_sel1 got %h want %h", {f3, ch3, onehot3, tick3}, {4'h6, 2'd1, 3'b010, 1'b1}); end
      sel3 = 2'd3;
      for (int k = 0; k < 2; k++) begin
         step();
         n_cmp++; if ({f3, ch3, onehot3, tick3} !== {4'h6, 2'd1, 3'b010, 1'b0}) begin n_bad++; $display("FAIL oor_sel3_hold got %h want %h", {f3, ch3, onehot3, tick3}, {4'h6, 2'd1, 3'b010, 1'b0}); end
      end
      sel3 = 2'd2;
      step();
      n_cmp++; if ({f3, ch3, onehot3, tick3} !== {4'h7, 2'd2, 3'b100, 1'b1}) begin n_bad++; $display("FAIL oor_sel2 got %h want %h", {f3, ch3, onehot3, tick3}, {4'h7, 2'd2, 3'b100, 1'b1}); end
   endtask

   task automatic test_enable_mode();
      w = 16'hDCBA; mask = 4'hF; sel = 2'd0;
      do_reset(1'b1);
      repeat (4) step();                 // ch=1, prescaler at 1
      en = 1'b0;
      step();
      n_cmp++; if ({f, ch, onehot, tick} !== {4'h0, 2'd1, 4'b0000, 1'b0}) begin n_bad++; $display("FAIL en_blank got %h want %h", {f, ch, onehot, tick}, {4'h0, 2'd1, 4'b0000, 1'b0}); end
      step(); step();
      n_cmp++; if ({ch, tick} !== {2'd1, 1'b0}) begin n_bad++; $display("FAIL en_hold got %h want %h", {ch, tick}, {2'd1, 1'b0}); end
      en = 1'b1;
      step();
      n_cmp++; if ({f, ch, onehot, tick} !== {4'hB, 2'd1, 4'b0010, 1'b0}) begin n_bad++; $display("FAIL en_resume got %h want %h", {f, ch, onehot, tick}, {4'hB, 2'd1, 4'b0010, 1'b0}); end
      step();
      n_cmp++; if ({ch, tick} !== {2'd2, 1'b1}) begin n_bad++; $display("FAIL en_resume_advance got %h want %h", {ch, tick}, {2'd2, 1'b1}); end
      step(); step();                    // prescaler at 2: next edge would wrap
      en = 1'b0;
      step();
      n_cmp++; if ({f, ch, tick} !== {4'h0, 2'd2, 1'b0}) begin n_bad++; $display("FAIL en_beats_wrap got %h want %h", {f, ch, tick}, {4'h0, 2'd2, 1'b0}); end
      en = 1'b1;
      step();
      n_cmp++; if ({f, ch, tick} !== {4'hD, 2'd3, 1'b1}) begin n_bad++; $display("FAIL en_late_wrap got %h want %h", {f, ch, tick}, {4'hD, 2'd3, 1'b1}); end
      step();                            // prescaler at 1
      mode = 1'b0; sel = 2'd0;
      step();
      n_cmp++; if ({f, ch, onehot, tick} !== {4'hA, 2'd0, 4'b0001, 1'b1}) begin n_bad++; $display("FAIL scan_to_manual got %h want %h", {f, ch, onehot, tick}, {4'hA, 2'd0, 4'b0001, 1'b1}); end
      mode = 1'b1;
      step(); step();
      n_cmp++; if ({ch, tick} !== {2'd0, 1'b0}) begin n_bad++; $display("FAIL manual_to_scan_wait got %h want %h", {ch, tick}, {2'd0, 1'b0}); end
      step();
      n_cmp++; if ({ch, tick} !== {2'd1, 1'b1}) begin n_bad++; $display("FAIL manual_to_scan_first got %h want %h", {ch, tick}, {2'd1, 1'b1}); end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; mode = 1'b0;
      sel = 2'd0; w = 16'hDCBA; mask = 4'hF;
      sel3 = 2'd0; w3 = 12'h765; mask3 = 3'b111;
      test_reset();
      test_manual();
      test_full_scan();
      test_masked_scan();
      test_out_of_range();
      test_enable_mode();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog sim time expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
